// File: rtl/weight_mem_pkg.sv
// Shared weight-memory line layout definitions.
// Used by both the fetch path and the loader, so the packing of weight
// slots and the bias field has a single source.
package weight_mem_pkg;

    // Every weight occupies a fixed 8-bit slot regardless of its precision.
    localparam int SLOT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        BIAS    = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } loader_state_e;

    // Weights per line. Any remainder of n/temp is dropped by design.
    function automatic int lanes(input int n, input int temp);
        return n / temp;
    endfunction

    // Minimum line width needed for the weight slots plus the bias field.
    function automatic int line_bits(input int n_lanes, input int bias_precision);
        return n_lanes * SLOT_W + bias_precision;
    endfunction

endpackage

// File: rtl/serial_memory_loader_if.sv
// Weight and bias stream handshake into the serial memory loader.
// master = host/DMA side, slave = loader side.
interface serial_memory_loader_if #(
    parameter int PRECISION      = 5,
    parameter int BIAS_PRECISION = 32
);
    logic                      w_valid;
    logic                      w_ready;
    logic [PRECISION-1:0]      w_data;
    logic                      b_valid;
    logic                      b_ready;
    logic [BIAS_PRECISION-1:0] b_data;

    modport master (
        output w_valid, w_data, b_valid, b_data,
        input  w_ready, b_ready
    );

    modport slave (
        input  w_valid, w_data, b_valid, b_data,
        output w_ready, b_ready
    );
endinterface

// File: rtl/weight_line_packer.sv
// Line buffer for the loader: one register per weight slot plus the bias
// register. The packed line is presented continuously; the owning FSM
// decides when it is written.
module weight_line_packer
    import weight_mem_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int LANE_W         = 1,
    parameter int PRECISION      = 5,
    parameter int BIAS_PRECISION = 32,
    parameter int BRAM_WIDTH     = 48
) (
    input  logic                      i_clk,
    input  logic                      i_clr,
    input  logic                      i_clear,
    input  logic                      i_slot_we,
    input  logic [LANE_W-1:0]         i_slot_idx,
    input  logic [PRECISION-1:0]      i_slot_data,
    input  logic                      i_bias_we,
    input  logic [BIAS_PRECISION-1:0] i_bias_data,
    output logic [BRAM_WIDTH-1:0]     o_line
);

    logic [PRECISION-1:0]      r_slot [LANES];
    logic [BIAS_PRECISION-1:0] r_bias;
    logic [BRAM_WIDTH-1:0]     w_line;

    // Slot and bias storage; clear wins over any write in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_clr || i_clear) begin
            for (int k = 0; k < LANES; k++) begin
                r_slot[k] <= '0;
            end
            r_bias <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (i_slot_we && (i_slot_idx == LANE_W'(k))) begin
                    r_slot[k] <= i_slot_data;
                end
            end
            if (i_bias_we) begin
                r_bias <= i_bias_data;
            end
        end
    end

    // Pack into the BRAM layout; unused slot bits and the MSBs stay zero.
    always_comb begin
        w_line = '0;
        for (int k = 0; k < LANES; k++) begin
            w_line[k*SLOT_W +: PRECISION] = r_slot[k];
        end
        w_line[LANES*SLOT_W +: BIAS_PRECISION] = r_bias;
    end

    assign o_line = w_line;

endmodule

// File: rtl/serial_memory_loader.sv
// serial_memory_loader: packs a weight/bias stream into weight-BRAM lines
// and issues one write per completed line, NLINES = M*TEMP lines per load.
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to add o_checksum,
// the XOR of every line written since the last accepted start.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | accepting weights into slots 0..LANES-1
// BIAS    | accepting the bias for the current line
// WRITE   | line presented to the BRAM for one enabled cycle
// DONE    | one-cycle completion pulse, back to IDLE
module serial_memory_loader
    import weight_mem_pkg::*;
#(
    parameter int  TEMP           = 2,
    parameter int  M              = 5,
    parameter int  N              = 5,
    parameter int  PRECISION      = 5,
    parameter int  BIAS_PRECISION = 32,
    parameter int  BRAM_WIDTH     = 48,
    localparam int NLINES         = M * TEMP,
    localparam int ADDR_W         = (NLINES > 1) ? $clog2(NLINES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    input  logic                  i_ce,
    input  logic                  i_start,
    serial_memory_loader_if.slave s_if,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [BRAM_WIDTH-1:0] o_mem_din,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [BRAM_WIDTH-1:0] o_checksum,
`endif
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int LANES  = lanes(N, TEMP);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NLINES - 1);

    if (LANES < 1) begin : g_lanes_check
        $error("N/TEMP must give at least one weight per line");
    end
    if (PRECISION > SLOT_W) begin : g_prec_check
        $error("PRECISION must fit in an 8-bit slot");
    end
    if (BRAM_WIDTH < line_bits(LANES, BIAS_PRECISION)) begin : g_width_check
        $error("BRAM_WIDTH too small for LANES slots plus bias");
    end

    loader_state_e          r_state;
    logic [LANE_W-1:0]      r_lane;
    logic [ADDR_W-1:0]      r_line;
    logic                   r_busy;

    logic                   w_w_acc;
    logic                   w_b_acc;
    logic                   w_start_acc;
    logic                   w_write;
    logic                   w_clear;
    logic [BRAM_WIDTH-1:0]  w_line;

    // Ready depends only on state and enable, never on valid.
    assign s_if.w_ready = i_ce && (r_state == COLLECT);
    assign s_if.b_ready = i_ce && (r_state == BIAS);

    assign w_w_acc     = s_if.w_valid && s_if.w_ready;
    assign w_b_acc     = s_if.b_valid && s_if.b_ready;
    assign w_start_acc = i_ce && (r_state == IDLE) && i_start;
    // A stalled WRITE holds its state, so the pulse fires once ce returns.
    assign w_write     = i_ce && (r_state == WRITE);
    // Fresh buffer for a new load and for every line after a write; the
    // last line is kept so o_mem_din still shows it after completion.
    assign w_clear     = w_start_acc || (w_write && (r_line != LAST_LINE));

    // Load sequencing: lane/line counters and busy flag.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= IDLE;
            r_lane  <= '0;
            r_line  <= '0;
            r_busy  <= 1'b0;
        end else if (i_ce) begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= COLLECT;
                        r_busy  <= 1'b1;
                        r_line  <= '0;
                        r_lane  <= '0;
                    end
                end
                COLLECT: begin
                    if (w_w_acc) begin
                        if (r_lane == LAST_LANE) begin
                            r_lane  <= '0;
                            r_state <= BIAS;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    if (w_b_acc) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (r_line == LAST_LINE) begin
                        r_state <= DONE;
                    end else begin
                        r_line  <= r_line + 1'b1;
                        r_state <= COLLECT;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_line  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    weight_line_packer #(
        .LANES          (LANES),
        .LANE_W         (LANE_W),
        .PRECISION      (PRECISION),
        .BIAS_PRECISION (BIAS_PRECISION),
        .BRAM_WIDTH     (BRAM_WIDTH)
    ) u_packer (
        .i_clk       (i_clk),
        .i_clr       (i_clr),
        .i_clear     (w_clear),
        .i_slot_we   (w_w_acc),
        .i_slot_idx  (r_lane),
        .i_slot_data (s_if.w_data),
        .i_bias_we   (w_b_acc),
        .i_bias_data (s_if.b_data),
        .o_line      (w_line)
    );

    assign o_mem_we   = w_write;
    assign o_mem_addr = r_line;
    assign o_mem_din  = w_line;
    assign o_busy     = r_busy;
    assign o_done     = i_ce && (r_state == DONE);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [BRAM_WIDTH-1:0] r_checksum;

    // Running XOR of written lines, restarted by each accepted start.
    always_ff @(posedge i_clk) begin
        if (i_clr || w_start_acc) begin
            r_checksum <= '0;
        end else if (w_write) begin
            r_checksum <= r_checksum ^ w_line;
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_serial_memory_loader.sv
// Self-checking bench for serial_memory_loader (default parameters:
// LANES=2, NLINES=10, BRAM_WIDTH=48). Expected lines come from a plain
// arithmetic model of the line layout.
module tb_serial_memory_loader;

    localparam int NL = 10;
    localparam int LN = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        ce;
    logic        start;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [47:0] mem_din;
    logic        busy;
    logic        done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [47:0] checksum;
`endif

    serial_memory_loader_if #(.PRECISION(5), .BIAS_PRECISION(32)) bus ();

    serial_memory_loader dut (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_ce       (ce),
        .i_start    (start),
        .s_if       (bus),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_din  (mem_din),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .o_checksum (checksum),
`endif
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Observed write log and protocol watch.
    logic [3:0]  mon_addr [$];
    logic [47:0] mon_din  [$];
    int          mon_cyc  [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hs_err   = 0;
    int          stall_err = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mon_addr.push_back(mem_addr);
            mon_din.push_back(mem_din);
            mon_cyc.push_back(cyc);
            if (ce !== 1'b1) stall_err++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (ce !== 1'b1) stall_err++;
        end
        if (bus.w_ready === 1'b1 && bus.b_ready === 1'b1) hs_err++;
        if (ce === 1'b0 && (bus.w_ready === 1'b1 || bus.b_ready === 1'b1)) hs_err++;
    end

    // Reference data for a full load.
    logic [4:0]  ld_w    [NL][LN];
    logic [31:0] ld_b    [NL];
    logic [47:0] ld_line [NL];
    logic [4:0]  q_w [$];
    logic [31:0] q_b [$];
    int          start_cyc;

    function automatic logic [47:0] model_line(input logic [4:0] w0, input logic [4:0] w1,
                                               input logic [31:0] b);
        return 48'(b) * 48'h10000 + 48'(w1) * 48'h100 + 48'(w0);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NL; i++) begin
            ld_w[i][0] = 5'($urandom);
            ld_w[i][1] = 5'($urandom);
            ld_b[i]    = $urandom;
            ld_line[i] = model_line(ld_w[i][0], ld_w[i][1], ld_b[i]);
        end
    endtask

    task automatic push_lines(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            q_w.push_back(ld_w[i][0]);
            q_w.push_back(ld_w[i][1]);
            q_b.push_back(ld_b[i]);
        end
    endtask

    task automatic clear_log();
        mon_addr.delete();
        mon_din.delete();
        mon_cyc.delete();
        done_cnt  = 0;
        hs_err    = 0;
        stall_err = 0;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Offers queued weights/biases with random gaps and ce drops; entered
    // and left at posedge+1. stall_write drops ce on the cycle after each
    // accepted bias, which is the WRITE cycle.
    task automatic drive_stream(input int gap_pct, input int ce_pct, input bit stall_write,
                                input int budget);
        int  n = 0;
        int  stall = 0;
        bit  wacc, bacc;
        while ((q_w.size() > 0 || q_b.size() > 0) && n < budget) begin
            if (stall > 0) begin
                ce = 1'b0;
                stall--;
            end else begin
                ce = ($urandom_range(99) >= ce_pct);
            end
            bus.w_valid = (q_w.size() > 0) && ($urandom_range(99) >= gap_pct);
            if (q_w.size() > 0) bus.w_data = q_w[0];
            bus.b_valid = (q_b.size() > 0) && ($urandom_range(99) >= gap_pct);
            if (q_b.size() > 0) bus.b_data = q_b[0];
            @(negedge clk);
            wacc = bus.w_valid && bus.w_ready;
            bacc = bus.b_valid && bus.b_ready;
            @(posedge clk); #1;
            if (wacc) void'(q_w.pop_front());
            if (bacc) begin
                void'(q_b.pop_front());
                if (stall_write) stall = 2;
            end
            n++;
        end
        bus.w_valid = 1'b0;
        bus.b_valid = 1'b0;
        ce = 1'b1;
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL stream_timeout: left w=%0d b=%0d after %0d cycles", q_w.size(), q_b.size(), n);
            q_w.delete();
            q_b.delete();
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b1; ce = 1'b1;
        bus.w_valid = 1'b0; bus.b_valid = 1'b0; bus.w_data = '0; bus.b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mem_we, done, busy, bus.w_ready, bus.b_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {mem_we, done, busy, bus.w_ready, bus.b_ready});
        end
        total++;
        if (mem_addr !== 4'd0 || mem_din !== 48'd0) begin
            bad++;
            $display("FAIL reset_bus: addr %h din %h want 0", mem_addr, mem_din);
        end
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || mon_addr.size() != 0) begin
            bad++;
            $display("FAIL start_with_clr: busy %b writes %0d want 0 0", busy, mon_addr.size());
        end
    endtask

    task automatic test_single_line();
        clear_log();
        q_w.push_back(5'h1F);
        q_w.push_back(5'h0A);
        q_b.push_back(32'hDEADBEEF);
        do_start();
        drive_stream(0, 0, 1'b0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (mon_addr.size() != 1) begin
            bad++;
            $display("FAIL single_count: got %0d writes want 1", mon_addr.size());
        end else begin
            total++;
            if (mon_addr[0] !== 4'd0 || mon_din[0] !== 48'hDEAD_BEEF_0A1F) begin
                bad++;
                $display("FAIL single_line: addr %h din %h want 0 deadbeef0a1f", mon_addr[0], mon_din[0]);
            end
            total++;
            if (mon_cyc[0] != start_cyc + 4) begin
                bad++;
                $display("FAIL single_latency: write at %0d want %0d", mon_cyc[0] - start_cyc, 4);
            end
        end
        pulse_clr();
    endtask

    task automatic test_full_load();
        logic [47:0] x = '0;
        fill_random();
        clear_log();
        push_lines(0, NL);
        do_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        drive_stream(0, 0, 1'b0, 200);
        wait_done(20);
        @(negedge clk);
        total++;
        if (mon_addr.size() != NL) begin
            bad++;
            $display("FAIL full_count: got %0d writes want %0d", mon_addr.size(), NL);
        end else begin
            for (int i = 0; i < NL; i++) begin
                total++;
                if (mon_addr[i] !== 4'(i) || mon_din[i] !== ld_line[i] || mon_cyc[i] != start_cyc + 4 + 4 * i) begin
                    bad++;
                    $display("FAIL full_line%0d: addr %h din %h cyc %0d want %h %h %0d", i,
                             mon_addr[i], mon_din[i], mon_cyc[i] - start_cyc, 4'(i), ld_line[i], 4 + 4 * i);
                end
                x = x ^ ld_line[i];
            end
        end
        total++;
        if (done_cnt != 1 || done_cyc != start_cyc + 41) begin
            bad++;
            $display("FAIL full_done: count %0d at %0d want 1 at 41", done_cnt, done_cyc - start_cyc);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_done: got %b want 0", busy);
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        total++;
        if (checksum !== x) begin
            bad++;
            $display("FAIL full_checksum: got %h want %h", checksum, x);
        end
`endif
    endtask

    task automatic test_random_gaps();
        clear_log();
        push_lines(0, NL);
        do_start();
        drive_stream(40, 25, 1'b1, 3000);
        wait_done(50);
        @(negedge clk);
        total++;
        if (mon_addr.size() != NL) begin
            bad++;
            $display("FAIL gaps_count: got %0d writes want %0d", mon_addr.size(), NL);
        end else begin
            for (int i = 0; i < NL; i++) begin
                total++;
                if (mon_addr[i] !== 4'(i) || mon_din[i] !== ld_line[i]) begin
                    bad++;
                    $display("FAIL gaps_line%0d: addr %h din %h want %h %h", i, mon_addr[i], mon_din[i], 4'(i), ld_line[i]);
                end
            end
        end
        total++;
        if (done_cnt != 1 || stall_err != 0 || hs_err != 0) begin
            bad++;
            $display("FAIL gaps_protocol: done %0d stall_err %0d hs_err %0d want 1 0 0", done_cnt, stall_err, hs_err);
        end
    endtask

    task automatic test_clr_mid_load();
        logic [4:0]  nw0, nw1;
        logic [31:0] nb;
        clear_log();
        push_lines(0, 3);
        q_w.push_back(ld_w[3][0]);
        do_start();
        drive_stream(30, 10, 1'b0, 1000);
        ce = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        ce = 1'b1;
        bus.w_valid = 1'b1; bus.b_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.w_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clk);
        total++;
        if (mon_addr.size() != 3 || done_cnt != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_abort: writes %0d done %0d busy %b want 3 0 0", mon_addr.size(), done_cnt, busy);
        end
        clear_log();
        nw0 = 5'($urandom); nw1 = 5'($urandom); nb = $urandom;
        q_w.push_back(nw0); q_w.push_back(nw1); q_b.push_back(nb);
        do_start();
        drive_stream(0, 0, 1'b0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (mon_addr.size() != 1) begin
            bad++;
            $display("FAIL restart_count: got %0d writes want 1", mon_addr.size());
        end else begin
            total++;
            if (mon_addr[0] !== 4'd0 || mon_din[0] !== model_line(nw0, nw1, nb)) begin
                bad++;
                $display("FAIL restart_line: addr %h din %h want 0 %h", mon_addr[0], mon_din[0], model_line(nw0, nw1, nb));
            end
        end
        pulse_clr();
    endtask

    task automatic test_start_while_busy();
        int early_b = 0;
        clear_log();
        do_start();
        bus.b_valid = 1'b1;
        bus.b_data  = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            if (bus.b_ready === 1'b1) early_b++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_data  = ld_w[0][0];
        @(posedge clk); #1;
        bus.w_data  = ld_w[0][1];
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        bus.b_data  = ld_b[0];
        @(posedge clk); #1;
        bus.b_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_lines(1, 1);
        drive_stream(0, 0, 1'b0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (early_b != 0 || hs_err != 0) begin
            bad++;
            $display("FAIL bias_early: b_ready high %0d cycles in COLLECT, hs_err %0d, want 0", early_b, hs_err);
        end
        total++;
        if (mon_addr.size() != 2) begin
            bad++;
            $display("FAIL busy_count: got %0d writes want 2", mon_addr.size());
        end else begin
            total++;
            if (mon_din[0] !== ld_line[0] || mon_addr[1] !== 4'd1 || mon_din[1] !== ld_line[1]) begin
                bad++;
                $display("FAIL busy_lines: %h @%h, %h @%h want %h @0, %h @1", mon_din[0], mon_addr[0],
                         mon_din[1], mon_addr[1], ld_line[0], ld_line[1]);
            end
        end
        total++;
        if (busy !== 1'b1 || done_cnt != 0) begin
            bad++;
            $display("FAIL busy_state: busy %b done %0d want 1 0", busy, done_cnt);
        end
        pulse_clr();
    endtask

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < NL; i++) begin
            ld_w[i][0] = '0;
            ld_w[i][1] = '0;
            ld_b[i]    = 32'(i);
        end
        clear_log();
        push_lines(0, NL);
        do_start();
        drive_stream(20, 10, 1'b1, 2000);
        wait_done(50);
        repeat (3) @(negedge clk);
        total++;
        if (checksum !== 48'h0000_0001_0000) begin
            bad++;
            $display("FAIL checksum_value: got %h want 000000010000", checksum);
        end
        do_start();
        total++;
        if (checksum !== 48'd0) begin
            bad++;
            $display("FAIL checksum_clear: got %h want 0", checksum);
        end
        pulse_clr();
    endtask
`endif

    initial begin
        test_reset();
        test_single_line();
        test_full_load();
        test_random_gaps();
        test_clr_mid_load();
        test_start_while_busy();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
